// File: rtl/scope_cmd_rx.sv
// scope_cmd_rx: host-to-scope command receiver.
// An 8N1 UART receiver feeds a 6-byte frame parser:
//   0xA5, OP, D2, D1, D0, CK   with CK = OP ^ D2 ^ D1 ^ D0.
// Accepted frames update the capture-control registers (interval, trig_level, run).
// Rejected frames pulse cmd_error and latch the reason in err_code.
// A stalled partial frame is abandoned after 20 bit-times of silence.
module scope_cmd_rx #(
  parameter int DELAY_FRAMES     = 234,      // clocks per UART bit, must be >= 8
  parameter int DEFAULT_INTERVAL = 2700000   // reset value of interval
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic        frame_err,
  output logic [23:0] interval,
  output logic [7:0]  trig_level,
  output logic        run,
  output logic        cmd_valid,
  output logic        cmd_error,
  output logic [1:0]  err_code
);

  localparam int CNT_W    = $clog2(DELAY_FRAMES);
  localparam int TO_LIMIT = 20 * DELAY_FRAMES;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [CNT_W-1:0] HALF_LOAD    = CNT_W'(DELAY_FRAMES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD    = CNT_W'(DELAY_FRAMES - 1);
  localparam logic [TO_W-1:0]  TO_MAX       = TO_W'(TO_LIMIT);
  localparam logic [23:0]      INTERVAL_RST = 24'(DEFAULT_INTERVAL);
  localparam logic [7:0]       SYNC_BYTE    = 8'hA5;

  localparam logic [1:0] ERR_CKSUM   = 2'd1;
  localparam logic [1:0] ERR_OPVAL   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    P_SYNC,
    P_OP,
    P_D2,
    P_D1,
    P_D0,
    P_CK
  } p_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rxs;

  // Two-flop synchronizer; resets to idle-high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
    // blocking here would let r_rxs see the new r_rx_meta in the same edge and drop a stage.
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rxs     <= r_rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // UART receive FSM
  // ---------------------------------------------------------------------------
  rx_state_t        r_rx_state;
  rx_state_t        w_rx_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_bit_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             w_cnt_zero;
  logic             w_byte_done;
  logic             w_stop_bad;
  logic [7:0]       r_rx_byte;
  logic             r_rx_byte_valid;
  logic             r_frame_err;

  assign w_cnt_zero = (r_bit_cnt == '0);

  // Receiver next-state: half-bit wait to centre on the start bit, then full-bit sample spacing.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned
    // (an unassigned path would infer a latch).
    w_rx_state_nxt = r_rx_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_byte_done    = 1'b0;
    w_stop_bad     = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (!r_rxs) begin
          w_rx_state_nxt = RX_START;
          w_bit_cnt_nxt  = HALF_LOAD;
        end
      end
      RX_START: begin
        if (w_cnt_zero) begin
          if (!r_rxs) begin
            w_rx_state_nxt = RX_DATA;
            w_bit_cnt_nxt  = FULL_LOAD;
            w_bit_idx_nxt  = 3'd0;
          end else begin
            // Start bit vanished before its centre: a glitch, not a byte.
            w_rx_state_nxt = RX_IDLE;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (w_cnt_zero) begin
          // LSB arrives first, so shift right and insert at the top.
          w_shift_nxt   = {r_rxs, r_shift[7:1]};
          w_bit_cnt_nxt = FULL_LOAD;
          if (r_bit_idx == 3'd7) begin
            w_rx_state_nxt = RX_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (w_cnt_zero) begin
          if (r_rxs) begin
            w_byte_done    = 1'b1;
            w_rx_state_nxt = RX_IDLE;
          end else begin
            // Wait for the line to go high so a long break reports only once.
            w_stop_bad     = 1'b1;
            w_rx_state_nxt = RX_WAIT_HIGH;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (r_rxs) begin
          w_rx_state_nxt = RX_IDLE;
        end
      end
      default: begin
        w_rx_state_nxt = RX_IDLE;
      end
    endcase
  end

  // Receiver state, counters and registered byte/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state      <= RX_IDLE;
      r_bit_cnt       <= '0;
      r_bit_idx       <= 3'd0;
      r_shift         <= 8'h00;
      r_rx_byte       <= 8'h00;
      r_rx_byte_valid <= 1'b0;
      r_frame_err     <= 1'b0;
    end else begin
      r_rx_state      <= w_rx_state_nxt;
      r_bit_cnt       <= w_bit_cnt_nxt;
      r_bit_idx       <= w_bit_idx_nxt;
      r_shift         <= w_shift_nxt;
      r_rx_byte_valid <= w_byte_done;
      r_frame_err     <= w_stop_bad;
      if (w_byte_done) begin
        r_rx_byte <= r_shift;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------------
  p_state_t         r_p_state;
  p_state_t         w_p_state_nxt;
  logic [7:0]       r_op;
  logic [7:0]       r_d2;
  logic [7:0]       r_d1;
  logic [7:0]       r_d0;
  logic [TO_W-1:0]  r_to_cnt;
  logic [23:0]      w_payload;
  logic             w_ck_match;
  logic             w_timeout;
  logic             w_accept;
  logic             w_reject;
  logic [1:0]       w_reject_code;
  logic             w_ld_interval;
  logic             w_ld_trig;
  logic             w_ld_run;
  logic [23:0]      r_interval;
  logic [7:0]       r_trig_level;
  logic             r_run;
  logic             r_cmd_valid;
  logic             r_cmd_error;
  logic [1:0]       r_err_code;

  assign w_payload  = {r_d2, r_d1, r_d0};
  assign w_ck_match = (r_rx_byte == (r_op ^ r_d2 ^ r_d1 ^ r_d0));
  // A byte arriving on the same cycle always wins over the timeout.
  assign w_timeout  = (r_p_state != P_SYNC) && (r_to_cnt == TO_MAX) && !r_rx_byte_valid;

  // Parser next-state and command decode; the checksum is judged before the opcode.
  always_comb begin
    w_p_state_nxt = r_p_state;
    w_accept      = 1'b0;
    w_reject      = 1'b0;
    w_reject_code = 2'd0;
    w_ld_interval = 1'b0;
    w_ld_trig     = 1'b0;
    w_ld_run      = 1'b0;
    if (r_frame_err) begin
      // A corrupted byte silently abandons any frame in progress.
      w_p_state_nxt = P_SYNC;
    end else if (r_rx_byte_valid) begin
      case (r_p_state)
        P_SYNC:  if (r_rx_byte == SYNC_BYTE) w_p_state_nxt = P_OP;
        P_OP:    w_p_state_nxt = P_D2;
        P_D2:    w_p_state_nxt = P_D1;
        P_D1:    w_p_state_nxt = P_D0;
        P_D0:    w_p_state_nxt = P_CK;
        P_CK: begin
          w_p_state_nxt = P_SYNC;
          if (!w_ck_match) begin
            w_reject      = 1'b1;
            w_reject_code = ERR_CKSUM;
          end else begin
            case (r_op)
              8'h01: begin
                if (w_payload == 24'd0) begin
                  w_reject      = 1'b1;
                  w_reject_code = ERR_OPVAL;
                end else begin
                  w_accept      = 1'b1;
                  w_ld_interval = 1'b1;
                end
              end
              8'h02: begin
                w_accept  = 1'b1;
                w_ld_trig = 1'b1;
              end
              8'h03: begin
                w_accept = 1'b1;
                w_ld_run = 1'b1;
              end
              default: begin
                w_reject      = 1'b1;
                w_reject_code = ERR_OPVAL;
              end
            endcase
          end
        end
        default: w_p_state_nxt = P_SYNC;
      endcase
    end else if (w_timeout) begin
      w_p_state_nxt = P_SYNC;
      w_reject      = 1'b1;
      w_reject_code = ERR_TIMEOUT;
    end
  end

  // Parser state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_state <= P_SYNC;
    end else begin
      r_p_state <= w_p_state_nxt;
    end
  end

  // Frame field capture and saturating inter-byte idle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 8'h00;
      r_d2     <= 8'h00;
      r_d1     <= 8'h00;
      r_d0     <= 8'h00;
      r_to_cnt <= '0;
    end else begin
      if (r_rx_byte_valid) begin
        r_to_cnt <= '0;
        case (r_p_state)
          P_OP:    r_op <= r_rx_byte;
          P_D2:    r_d2 <= r_rx_byte;
          P_D1:    r_d1 <= r_rx_byte;
          P_D0:    r_d0 <= r_rx_byte;
          default: ;
        endcase
      end else if (r_to_cnt != TO_MAX) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  // Capture-control registers and command result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_interval   <= INTERVAL_RST;
      r_trig_level <= 8'h80;
      r_run        <= 1'b1;
      r_cmd_valid  <= 1'b0;
      r_cmd_error  <= 1'b0;
      r_err_code   <= 2'd0;
    end else begin
      r_cmd_valid <= w_accept;
      r_cmd_error <= w_reject;
      if (w_reject)      r_err_code   <= w_reject_code;
      if (w_ld_interval) r_interval   <= w_payload;
      if (w_ld_trig)     r_trig_level <= r_d0;
      if (w_ld_run)      r_run        <= r_d0[0];
    end
  end

  assign rx_byte       = r_rx_byte;
  assign rx_byte_valid = r_rx_byte_valid;
  assign frame_err     = r_frame_err;
  assign interval      = r_interval;
  assign trig_level    = r_trig_level;
  assign run           = r_run;
  assign cmd_valid     = r_cmd_valid;
  assign cmd_error     = r_cmd_error;
  assign err_code      = r_err_code;

endmodule

// File: tb/tb_scope_cmd_rx.sv
// Self-checking bench for scope_cmd_rx: directed scenarios plus random frames,
// judged against a frame-level behavioural model of the command registers.
module tb_scope_cmd_rx;

  localparam int D       = 16;
  localparam int DEF_INT = 2700000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rx;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        frame_err;
  logic [23:0] interval;
  logic [7:0]  trig_level;
  logic        run;
  logic        cmd_valid;
  logic        cmd_error;
  logic [1:0]  err_code;

  scope_cmd_rx #(
    .DELAY_FRAMES    (D),
    .DEFAULT_INTERVAL(DEF_INT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rx      (uart_rx),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .frame_err    (frame_err),
    .interval     (interval),
    .trig_level   (trig_level),
    .run          (run),
    .cmd_valid    (cmd_valid),
    .cmd_error    (cmd_error),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int   n_rxv = 0, n_ferr = 0, n_cv = 0, n_ce = 0, n_both = 0, n_long = 0;
  int   valid_cyc = 0;
  logic p_rxv = 1'b0, p_ferr = 1'b0, p_cv = 1'b0, p_ce = 1'b0;

  always @(negedge clk) begin
    if (rx_byte_valid) begin
      n_rxv++;
      valid_cyc = cyc;
    end
    if (frame_err) n_ferr++;
    if (cmd_valid) n_cv++;
    if (cmd_error) n_ce++;
    if (cmd_valid && cmd_error) n_both++;
    if ((rx_byte_valid && p_rxv) || (frame_err && p_ferr) ||
        (cmd_valid && p_cv) || (cmd_error && p_ce)) n_long++;
    p_rxv  = rx_byte_valid;
    p_ferr = frame_err;
    p_cv   = cmd_valid;
    p_ce   = cmd_error;
  end

  // Behavioural model of the command registers.
  logic [23:0] m_interval;
  logic [7:0]  m_trig;
  logic        m_run;
  logic [1:0]  m_err;

  task automatic model_reset();
    m_interval = 24'(DEF_INT);
    m_trig     = 8'h80;
    m_run      = 1'b1;
    m_err      = 2'd0;
  endtask

  task automatic model_frame(input logic [7:0] op, d2, d1, d0, ck,
                             output int exp_cv, output int exp_ce);
    int payload;
    payload = int'(d2) * 65536 + int'(d1) * 256 + int'(d0);
    exp_cv  = 0;
    exp_ce  = 0;
    if ((op ^ d2 ^ d1 ^ d0) != ck) begin
      exp_ce = 1;
      m_err  = 2'd1;
    end else if (op == 8'h01 && payload != 0) begin
      m_interval = 24'(payload);
      exp_cv     = 1;
    end else if (op == 8'h02) begin
      m_trig = d0;
      exp_cv = 1;
    end else if (op == 8'h03) begin
      m_run  = d0[0];
      exp_cv = 1;
    end else begin
      exp_ce = 1;
      m_err  = 2'd2;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line drivers: inputs change on the falling edge only.
  int last_start = 0;

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (D) @(negedge clk);
  endtask

  task automatic send_raw(input logic [7:0] b, input logic stop_ok);
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    if (!stop_ok) drive_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_raw(b, 1'b1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".interval"}, interval, m_interval);
    check({tag, ".trig"}, trig_level, m_trig);
    check({tag, ".run"}, run, m_run);
    check({tag, ".err_code"}, err_code, m_err);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] op, d2, d1, d0, ck);
    int rxv0, cv0, ce0, ecv, ece;
    rxv0 = n_rxv;
    cv0  = n_cv;
    ce0  = n_ce;
    send_byte(8'hA5);
    send_byte(op);
    send_byte(d2);
    send_byte(d1);
    send_byte(d0);
    send_byte(ck);
    settle(3);
    model_frame(op, d2, d1, d0, ck, ecv, ece);
    check({tag, ".rxv"}, n_rxv - rxv0, 6);
    check({tag, ".cmd_valid"}, n_cv - cv0, ecv);
    check({tag, ".cmd_error"}, n_ce - ce0, ece);
    check({tag, ".rx_byte"}, rx_byte, ck);
    check_regs(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rx_byte"}, rx_byte, 8'h00);
    check({tag, ".rxv"}, rx_byte_valid, 1'b0);
    check({tag, ".ferr"}, frame_err, 1'b0);
    check({tag, ".interval"}, interval, 24'(DEF_INT));
    check({tag, ".trig"}, trig_level, 8'h80);
    check({tag, ".run"}, run, 1'b1);
    check({tag, ".cmd_valid"}, cmd_valid, 1'b0);
    check({tag, ".cmd_error"}, cmd_error, 1'b0);
    check({tag, ".err_code"}, err_code, 2'd0);
  endtask

  initial begin
    int rxv0, ferr0, cv0, ce0, lat, k;
    logic [7:0] op, d2, d1, d0, ck;

    rst_n   = 1'b0;
    uart_rx = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    settle(2);
    check_reset_outputs("reset");

    // Single byte: latency from start edge, and ignored by the parser in SYNC.
    rxv0 = n_rxv; cv0 = n_cv; ce0 = n_ce;
    send_byte(8'h5A);
    settle(3);
    lat = valid_cyc - last_start;
    check("lat.count", n_rxv - rxv0, 1);
    check("lat.byte", rx_byte, 8'h5A);
    check("lat.window", (lat >= 3 + D / 2 + 9 * D - 1) && (lat <= 3 + D / 2 + 9 * D + 1), 1'b1);
    check("lat.no_cmd", (n_cv - cv0) + (n_ce - ce0), 0);

    // Directed command frames.
    do_frame("set_interval", 8'h01, 8'h00, 8'h03, 8'hE8, 8'hEA);
    check("set_interval.value", interval, 24'd1000);
    do_frame("bad_ck", 8'h02, 8'h00, 8'h00, 8'h40, 8'h00);
    do_frame("trig40", 8'h02, 8'h00, 8'h00, 8'h40, 8'h42);
    check("trig40.value", trig_level, 8'h40);
    do_frame("bad_op", 8'h07, 8'h00, 8'h00, 8'h00, 8'h07);
    do_frame("zero_int", 8'h01, 8'h00, 8'h00, 8'h00, 8'h01);
    check("zero_int.keep", interval, 24'd1000);

    // Stop bit low mid-frame: one frame_err, parser drops the frame silently.
    rxv0 = n_rxv; ferr0 = n_ferr; ce0 = n_ce;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_raw(8'h33, 1'b0);
    settle(D);
    check("stop_low.ferr", n_ferr - ferr0, 1);
    check("stop_low.rxv", n_rxv - rxv0, 2);
    check("stop_low.rx_byte", rx_byte, 8'h01);
    check("stop_low.cmd_error", n_ce - ce0, 0);
    do_frame("after_ferr", 8'h02, 8'h00, 8'h00, 8'h11, 8'h13);

    // Short glitch: no output at all.
    rxv0 = n_rxv; ferr0 = n_ferr;
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    settle(2 * D);
    check("glitch.quiet", (n_rxv - rxv0) + (n_ferr - ferr0), 0);

    // Break of 50 bit-times: exactly one frame_err, then reception resumes.
    rxv0 = n_rxv; ferr0 = n_ferr;
    uart_rx = 1'b0;
    repeat (50 * D) @(negedge clk);
    uart_rx = 1'b1;
    settle(2 * D);
    check("break.ferr", n_ferr - ferr0, 1);
    check("break.rxv", n_rxv - rxv0, 0);
    do_frame("after_break", 8'h03, 8'h00, 8'h00, 8'h01, 8'h02);

    // Inter-byte timeout, then resync past leading junk.
    cv0 = n_cv; ce0 = n_ce;
    send_byte(8'hA5);
    send_byte(8'h03);
    k = 0;
    while (n_ce == ce0 && k < 25 * D) begin
      @(negedge clk);
      #1;
      k++;
    end
    m_err = 2'd3;
    check("timeout.cmd_error", n_ce - ce0, 1);
    check("timeout.cmd_valid", n_cv - cv0, 0);
    check("timeout.err_code", err_code, 2'd3);
    check("timeout.window", (k >= 19 * D) && (k <= 21 * D), 1'b1);
    send_byte(8'h00);
    do_frame("resync", 8'h03, 8'h00, 8'h00, 8'h00, 8'h03);
    check("resync.run", run, 1'b0);

    // Random frames against the model.
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0:       op = 8'h01;
        1:       op = 8'h02;
        2:       op = 8'h03;
        default: op = 8'($urandom);
      endcase
      d2 = 8'($urandom);
      d1 = 8'($urandom);
      d0 = 8'($urandom);
      if (op == 8'h01 && $urandom_range(0, 3) == 0) begin
        d2 = 8'h00; d1 = 8'h00; d0 = 8'h00;
      end
      ck = op ^ d2 ^ d1 ^ d0;
      if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      do_frame($sformatf("rnd%0d", i), op, d2, d1, d0, ck);
    end

    // Reset in the middle of D1 of an interval frame.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    model_reset();
    settle(2);
    check_reset_outputs("mid_reset");
    rxv0 = n_rxv; ferr0 = n_ferr; cv0 = n_cv; ce0 = n_ce;
    rst_n = 1'b1;
    settle(3 * D);
    check("mid_reset.no_pulse",
          (n_rxv - rxv0) + (n_ferr - ferr0) + (n_cv - cv0) + (n_ce - ce0), 0);
    do_frame("post_reset", 8'h01, 8'h12, 8'h34, 8'h56, 8'h01 ^ 8'h12 ^ 8'h34 ^ 8'h56);

    check("pulse.exclusive", n_both, 0);
    check("pulse.width", n_long, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
